i2c_bus_conditioner: RTL and testbench

Front-end conditioner for the I2C address translator. It sits between the raw SCL/SDA pad inputs and the translator's I2C slave and master engines. It synchronises and glitch-filters both lines and produces single-cycle SCL edge and START/STOP/repeated-START strobes. It also tracks bus ownership, with a stuck-SCL-low timeout, so downstream engines consume clean, clk-domain events instead of raw pins.

---
 rtl/i2c_bus_conditioner.sv | 147 ++++++++++++++
 tb/tb_i2c_bus_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_conditioner.sv
// +----------------------------------------------------------------------+
// | i2c_bus_conditioner - SCL/SDA sync + glitch filter, bus event strobes |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module i2c_bus_conditioner #(
   parameter int FILTER_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_f,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic rstart_det,
   output logic stop_det,
   output logic bus_busy,
   output logic scl_timeout
);

   localparam int             TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit             TO_EN     = (TIMEOUT_CYCLES > 0);
   localparam logic [3:0]     FILT_LAST = 4'(FILTER_CYCLES - 1);
   localparam logic [TW-1:0]  TO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t        state_q;
   logic          scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
   logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
   logic [3:0]    scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          scl_rise_q, scl_fall_q, start_q, rstart_q, stop_q, busy_q, timeout_q;

   logic w_scl_diff, w_sda_diff, w_scl_upd, w_sda_upd;
   logic w_start, w_stop, w_to_fire;

   // A line is accepted only after FILTER_CYCLES consecutive disagreeing samples.
   assign w_scl_diff = scl_s2_q ^ scl_f_q;
   assign w_sda_diff = sda_s2_q ^ sda_f_q;
   assign w_scl_upd  = w_scl_diff & (scl_cnt_q == FILT_LAST);
   assign w_sda_upd  = w_sda_diff & (sda_cnt_q == FILT_LAST);

   // START/STOP need SCL steady high across the SDA transition.
   assign w_start   = w_sda_upd &  sda_f_q & scl_f_q & ~w_scl_upd;
   assign w_stop    = w_sda_upd & ~sda_f_q & scl_f_q & ~w_scl_upd;
   assign w_to_fire = TO_EN && (state_q == ST_BUSY) && !scl_f_q && (to_cnt_q == TO_LAST);

   always_comb begin
      scl_f_d   = scl_f_q;
      sda_f_d   = sda_f_q;
      scl_cnt_d = 4'd0;
      sda_cnt_d = 4'd0;
      to_cnt_d  = '0;
      if (w_scl_upd)       scl_f_d   = scl_s2_q;
      else if (w_scl_diff) scl_cnt_d = scl_cnt_q + 4'd1;
      if (w_sda_upd)       sda_f_d   = sda_s2_q;
      else if (w_sda_diff) sda_cnt_d = sda_cnt_q + 4'd1;
      if (TO_EN && (state_q == ST_BUSY) && !scl_f_q && !w_to_fire)
         to_cnt_d = to_cnt_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_s1_q  <= 1'b1;
         scl_s2_q  <= 1'b1;
         sda_s1_q  <= 1'b1;
         sda_s2_q  <= 1'b1;
         scl_f_q   <= 1'b1;
         sda_f_q   <= 1'b1;
         scl_cnt_q <= 4'd0;
         sda_cnt_q <= 4'd0;
         to_cnt_q  <= '0;
      end else begin
         scl_s1_q  <= scl_in;
         scl_s2_q  <= scl_s1_q;
         sda_s1_q  <= sda_in;
         sda_s2_q  <= sda_s1_q;
         scl_f_q   <= scl_f_d;
         sda_f_q   <= sda_f_d;
         scl_cnt_q <= scl_cnt_d;
         sda_cnt_q <= sda_cnt_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         rstart_q   <= 1'b0;
         stop_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         scl_rise_q <= w_scl_upd & ~scl_f_q;
         scl_fall_q <= w_scl_upd &  scl_f_q;
         start_q    <= w_start;
         rstart_q   <= w_start & (state_q == ST_BUSY);
         stop_q     <= w_stop;
         timeout_q  <= w_to_fire & ~w_stop;
         case (state_q)
            ST_IDLE: begin
               if (w_start) begin
                  state_q <= ST_BUSY;
                  busy_q  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_start) begin
                  state_q <= ST_BUSY;
               end else if (w_stop || w_to_fire) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign scl_f       = scl_f_q;
   assign sda_f       = sda_f_q;
   assign scl_rise    = scl_rise_q;
   assign scl_fall    = scl_fall_q;
   assign start_det   = start_q;
   assign rstart_det  = rstart_q;
   assign stop_det    = stop_q;
   assign bus_busy    = busy_q;
   assign scl_timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed I2C scenarios plus random line noise,
// checked every cycle against a sliding-window behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_bus_conditioner;

   localparam int F = 4;
   localparam int T = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl_in = 1'b1;
   logic sda_in = 1'b1;
   logic scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy, scl_timeout;

   i2c_bus_conditioner #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
      .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_det(start_det), .rstart_det(rstart_det), .stop_det(stop_det),
      .bus_busy(bus_busy), .scl_timeout(scl_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Filtered level flips once the F most recent samples the filter has seen
   // (raw samples from 2..F+1 edges ago) all disagree with it.
   bit hs[F+1];
   bit hd[F+1];
   bit m_scl, m_sda, m_busy, m_rise, m_fall, m_start, m_rstart, m_stop, m_to;
   int m_low;

   task automatic model_reset();
      for (int i = 0; i <= F; i++) begin hs[i] = 1'b1; hd[i] = 1'b1; end
      m_scl = 1; m_sda = 1; m_busy = 0; m_low = 0;
      m_rise = 0; m_fall = 0; m_start = 0; m_rstart = 0; m_stop = 0; m_to = 0;
   endtask

   task automatic model_step(input bit rs, input bit rd);
      bit os, od, ob, fs, fd, ch, fire;
      os = m_scl; od = m_sda; ob = m_busy; fs = 1; fd = 1; fire = 0;
      for (int i = 0; i < F; i++) begin
         if (hs[i] == m_scl) fs = 0;
         if (hd[i] == m_sda) fd = 0;
      end
      for (int i = 0; i < F; i++) begin hs[i] = hs[i+1]; hd[i] = hd[i+1]; end
      hs[F] = rs; hd[F] = rd;
      if (fs) m_scl = !m_scl;
      if (fd) m_sda = !m_sda;
      ch = (m_scl != os);
      m_rise  = ch && m_scl;
      m_fall  = ch && !m_scl;
      m_start = od && !m_sda && os && !ch;
      m_stop  = !od && m_sda && os && !ch;
      m_rstart = m_start && ob;
      if (ob && !os) begin
         m_low++;
         if (m_low == T) begin fire = 1; m_low = 0; end
      end else begin
         m_low = 0;
      end
      if (m_stop) begin m_busy = 0; fire = 0; end
      else if (m_start) m_busy = 1;
      else if (fire) m_busy = 0;
      m_to = fire;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step(scl_in, sda_in);
      end
   end

   // ---------------- per-cycle compare + event counters ----------------
   // counter index: 0 rise, 1 fall, 2 start, 3 rstart, 4 stop, 5 timeout, 6 busy cycles
   int dc[7], mc[7], bd[7], bm[7];
   int cyc = 0, fall_cyc = 0, to_cyc = 0, rs_ok = 0, rs_base = 0;

   function automatic logic [8:0] dvec();
      return {scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det, bus_busy, scl_timeout};
   endfunction

   initial begin
      for (int i = 0; i < 7; i++) begin dc[i] = 0; mc[i] = 0; end
      forever begin
         @(negedge clk);
         cyc++;
         check("outputs_vs_model", 32'(dvec()),
               32'({m_scl, m_sda, m_rise, m_fall, m_start, m_rstart, m_stop, m_busy, m_to}));
         dc[0] += int'(scl_rise); dc[1] += int'(scl_fall); dc[2] += int'(start_det);
         dc[3] += int'(rstart_det); dc[4] += int'(stop_det); dc[5] += int'(scl_timeout);
         dc[6] += int'(bus_busy);
         mc[0] += int'(m_rise); mc[1] += int'(m_fall); mc[2] += int'(m_start);
         mc[3] += int'(m_rstart); mc[4] += int'(m_stop); mc[5] += int'(m_to);
         mc[6] += int'(m_busy);
         if (scl_fall) fall_cyc = cyc;
         if (scl_timeout) to_cyc = cyc;
         if (rstart_det && start_det && bus_busy) rs_ok++;
      end
   end

   task automatic snap();
      for (int i = 0; i < 7; i++) begin bd[i] = dc[i]; bm[i] = mc[i]; end
      rs_base = rs_ok;
   endtask

   task automatic expect_cnt(input string name, input int idx, input int exp);
      check({name, "_dut"}, 32'(dc[idx] - bd[idx]), 32'(exp));
      check({name, "_model"}, 32'(mc[idx] - bm[idx]), 32'(exp));
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input bit b);
      scl_in = 0; hold(3);
      sda_in = b; hold(7);
      scl_in = 1; hold(10);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   int rem_s, rem_d;
   logic [7:0] data;

   initial begin
      // reset state
      hold(3);
      check("reset_outputs", 32'(dvec()), 32'h180);
      rst_n = 1; hold(5);

      // short SDA glitch is swallowed
      snap();
      sda_in = 0; hold(3); sda_in = 1; hold(12);
      expect_cnt("glitch_start", 2, 0);
      check("glitch_sda_f", 32'(sda_f), 32'h1);

      // 6-cycle SDA low pulse: START lands at edge 6, then STOP
      snap();
      sda_in = 0;
      repeat (5) @(posedge clk);
      #1 check("sda_f_before_edge6", 32'(sda_f), 32'h1);
      @(posedge clk);
      #1 check("edge6_sda_start_busy", 32'({sda_f, start_det, bus_busy}), 32'h3);
      hold(1); sda_in = 1; hold(12);
      expect_cnt("pulse_start", 2, 1);
      expect_cnt("pulse_stop", 4, 1);

      // full frame: 0x50 write + data byte
      snap();
      data = 8'($urandom);
      sda_in = 0; hold(10);
      send_byte(8'hA0); send_bit(0);
      send_byte(data); send_bit(0);
      sda_in = 1; hold(12);
      expect_cnt("frame_rise", 0, 18);
      expect_cnt("frame_fall", 1, 18);
      expect_cnt("frame_start", 2, 1);
      expect_cnt("frame_stop", 4, 1);
      expect_cnt("frame_busy_cycles", 6, 370);

      // repeated START after the address byte
      snap();
      sda_in = 0; hold(10);
      send_byte(8'hA0); send_bit(0);
      scl_in = 0; hold(3); sda_in = 1; hold(7); scl_in = 1; hold(10);
      sda_in = 0; hold(10);
      sda_in = 1; hold(12);
      expect_cnt("rs_start", 2, 2);
      expect_cnt("rs_rstart", 3, 1);
      expect_cnt("rs_busy_cycles", 6, 220);
      check("rs_coincident", 32'(rs_ok - rs_base), 32'h1);

      // stuck SCL low for 40 cycles: one timeout 20 cycles after the fall
      snap();
      sda_in = 0; hold(10);
      scl_in = 0; hold(40); scl_in = 1; hold(10);
      sda_in = 1; hold(12);
      expect_cnt("to_fire", 5, 1);
      check("to_delay", 32'(to_cyc - fall_cyc), 32'd20);
      expect_cnt("to_busy_cycles", 6, 30);
      expect_cnt("to_idle_stop", 4, 1);

      // SCL released after 19 cycles: no timeout
      snap();
      sda_in = 0; hold(10);
      scl_in = 0; hold(19); scl_in = 1; hold(10);
      sda_in = 1; hold(12);
      expect_cnt("to19_fire", 5, 0);
      expect_cnt("to19_busy_cycles", 6, 39);

      // simultaneous SCL+SDA change while SCL high
      snap();
      scl_in = 0; sda_in = 0; hold(10);
      scl_in = 1; sda_in = 1; hold(10);
      expect_cnt("simul_fall", 1, 1);
      expect_cnt("simul_rise", 0, 1);
      expect_cnt("simul_start", 2, 0);
      expect_cnt("simul_stop", 4, 0);

      // reset mid-byte, then release with SCL=1, SDA=0
      sda_in = 0; hold(10);
      send_bit(1);
      scl_in = 0; hold(3); sda_in = 0; hold(8);
      check("pre_reset_busy_sclf", 32'({bus_busy, scl_f}), 32'h2);
      @(posedge clk); #2 rst_n = 0;
      #1 check("async_reset_outputs", 32'(dvec()), 32'h180);
      hold(2);
      scl_in = 1; sda_in = 0; rst_n = 1;
      snap();
      repeat (5) @(posedge clk);
      #1 check("post_reset_no_start_yet", 32'(start_det), 32'h0);
      @(posedge clk);
      #1 check("post_reset_start_edge6", 32'({start_det, bus_busy}), 32'h3);
      hold(1); sda_in = 1; hold(12);
      expect_cnt("post_reset_stop", 4, 1);

      // random line noise with mixed short glitches and long holds
      rem_s = 0; rem_d = 0;
      for (int c = 0; c < 3000; c++) begin
         if (rem_s == 0) begin
            scl_in = 1'($urandom_range(0, 1));
            rem_s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
         end
         if (rem_d == 0) begin
            sda_in = 1'($urandom_range(0, 1));
            rem_d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
         end
         rem_s--; rem_d--;
         hold(1);
      end
      scl_in = 1; sda_in = 1; hold(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
